// File: rtl/tms_bus_master.sv
// rtl/tms_bus_master.sv - TI-99/4A expansion bus initiator: 16-bit word requests as two byte cycles
//
// Purpose: acts as the console side of the 8-bit multiplexed expansion bus.
// Each accepted word request is split into an odd-byte cycle (A15=1, wdata[7:0]
// or rdata[7:0]) followed by an even-byte cycle (A15=0, wdata[15:8] or
// rdata[15:8]). Each byte cycle is SETUP -> STROBE -> HOLD. PHI3 is free-running.
//
// Ports:
//   clk, reset          system clock; asynchronous active-low reset (synchronous release)
//   req, wr, addr, wdata  request interface, sampled while idle
//   busy, done, err, rdata  transaction status and read word
//   bus_addr, bus_a15   A0..A14 and byte-select line
//   memen_n, dbin, we_n bus control strobes
//   bus_ready           responder READY (low inserts wait states)
//   bus_dout, bus_doe, bus_din  data bus driver / enable / receiver
//   phi3                free-running clock, period 2*PHI3_DIV clk
module tms_bus_master #(
  parameter int T_SETUP  = 4,
  parameter int T_STROBE = 8,
  parameter int T_HOLD   = 2,
  parameter int WAIT_MAX = 255,
  parameter int PHI3_DIV = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic [14:0] bus_addr,
  output logic        bus_a15,
  output logic        memen_n,
  output logic        dbin,
  output logic        we_n,
  input  logic        bus_ready,
  output logic [7:0]  bus_dout,
  output logic        bus_doe,
  input  logic [7:0]  bus_din,
  output logic        phi3
);

  localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam int PW = (PHI3_DIV > 1) ? $clog2(PHI3_DIV) : 1;
  localparam logic [WW-1:0] WAIT_LIM  = WW'(WAIT_MAX);
  localparam logic [7:0]    SETUP_END = 8'(T_SETUP - 1);
  localparam logic [7:0]    STRB_END  = 8'(T_STROBE - 1);
  localparam logic [7:0]    HOLD_END  = 8'(T_HOLD - 1);
  localparam logic [PW-1:0] PHI_END   = PW'(PHI3_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [1:0]    rst_pipe;
  logic          rst_n_int;
  logic [7:0]    cnt;
  logic [WW-1:0] wait_cnt;
  logic          wr_q;
  logic [14:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          byte_sel;   // 1 = odd (low) byte, 0 = even (high) byte
  logic          err_q;
  logic [15:0]   rdata_q;
  logic [PW-1:0] phi_cnt;
  logic          phi_q;
  logic          active;
  logic          strobe_min;
  logic          hold_last;
  logic          unused_addr_bit;

  assign unused_addr_bit = addr[0];

  // Assertion takes effect at once; release is retimed to clk so no flop
  // leaves reset on a different edge than its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n_int = rst_pipe[1];

  assign active     = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
  assign strobe_min = (cnt == STRB_END);
  assign hold_last  = (cnt == HOLD_END);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) state <= S_IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (req) next_state = S_SETUP;
      S_SETUP:  if (cnt == SETUP_END) next_state = S_STROBE;
      // Once the minimum strobe has elapsed, READY ends the phase; a
      // responder that never answers is cut off after WAIT_MAX waits.
      S_STROBE: if (strobe_min && (bus_ready || wait_cnt == WAIT_LIM)) next_state = S_HOLD;
      S_HOLD: begin
        if (hold_last) begin
          if (byte_sel && !err_q) next_state = S_SETUP;
          else                    next_state = S_DONE;
        end
      end
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // cnt freezes at the last minimum strobe cycle while wait_cnt counts waits.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cnt      <= '0;
      wait_cnt <= '0;
    end else if (next_state != state) begin
      cnt      <= '0;
      wait_cnt <= '0;
    end else if (state == S_STROBE && strobe_min) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else if (active) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      byte_sel <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            wr_q     <= wr;
            addr_q   <= addr[15:1];
            wdata_q  <= wdata;
            byte_sel <= 1'b1;
            err_q    <= 1'b0;
          end
        end
        S_STROBE: begin
          if (strobe_min) begin
            if (bus_ready) begin
              if (!wr_q) begin
                if (byte_sel) rdata_q[7:0]  <= bus_din;
                else          rdata_q[15:8] <= bus_din;
              end
            end else if (wait_cnt == WAIT_LIM) begin
              err_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (hold_last && byte_sel && !err_q) byte_sel <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      phi_cnt <= '0;
      phi_q   <= 1'b0;
    end else if (phi_cnt == PHI_END) begin
      phi_cnt <= '0;
      phi_q   <= ~phi_q;
    end else begin
      phi_cnt <= phi_cnt + 1'b1;
    end
  end

  always_comb begin
    busy     = active;
    done     = (state == S_DONE);
    err      = err_q;
    rdata    = rdata_q;
    bus_addr = addr_q;
    bus_a15  = byte_sel;
    memen_n  = !active;
    dbin     = active && !wr_q;
    bus_doe  = active && wr_q;
    we_n     = !((state == S_STROBE) && wr_q);
    bus_dout = 8'h00;
    if (active && wr_q) bus_dout = byte_sel ? wdata_q[7:0] : wdata_q[15:8];
    phi3     = phi_q;
  end

endmodule

// File: tb/tb_tms_bus_master.sv
// tb/tb_tms_bus_master.sv - directed self-checking bench for tms_bus_master
module tb_tms_bus_master;

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy, done, err;
  logic [15:0] rdata;
  logic [14:0] bus_addr;
  logic        bus_a15, memen_n, dbin, we_n;
  logic        bus_ready;
  logic [7:0]  bus_dout;
  logic        bus_doe;
  logic [7:0]  bus_din;
  logic        phi3;
  logic [7:0]  din_odd, din_even;

  logic        req2, ready2;
  logic [7:0]  din2;
  logic        busy2, done2, err2;
  logic [15:0] rdata2;
  logic [14:0] unused_addr2;
  logic        a15_2, memen_n2;
  logic        unused_dbin2, unused_we_n2, unused_doe2, unused_phi3_2;
  logic [7:0]  unused_dout2;

  int checks = 0;
  int passed = 0;

  logic phi_en = 1'b0;
  int   phi_c = 0, phi_min = 1000, phi_max = 0, phi_n = 0;
  logic phi_last = 1'b0, phi_seen = 1'b0;

  tms_bus_master dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .bus_addr(bus_addr), .bus_a15(bus_a15), .memen_n(memen_n), .dbin(dbin), .we_n(we_n),
    .bus_ready(bus_ready), .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(bus_din),
    .phi3(phi3)
  );

  tms_bus_master #(.WAIT_MAX(3)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy2), .done(done2), .err(err2), .rdata(rdata2),
    .bus_addr(unused_addr2), .bus_a15(a15_2), .memen_n(memen_n2), .dbin(unused_dbin2),
    .we_n(unused_we_n2), .bus_ready(ready2), .bus_dout(unused_dout2), .bus_doe(unused_doe2),
    .bus_din(din2), .phi3(unused_phi3_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus_din = bus_a15 ? din_odd : din_even;

  always @(negedge clk) begin
    if (!phi_en) begin
      phi_c    = 0;
      phi_seen = 1'b0;
      phi_last = phi3;
    end else begin
      phi_c++;
      if (phi3 !== phi_last) begin
        if (phi_seen) begin
          phi_n++;
          if (phi_c < phi_min) phi_min = phi_c;
          if (phi_c > phi_max) phi_max = phi_c;
        end
        phi_seen = 1'b1;
        phi_c    = 0;
      end
      phi_last = phi3;
    end
  end

  // Issues one request and observes it cycle by cycle; cycle 1 is the first busy cycle.
  task automatic run_txn(input logic w, input logic [15:0] a, input logic [15:0] d, input int even_low,
                         output int done_cyc, output logic busy1,
                         output int mem_odd, output int mem_even, output int we_odd, output int we_even,
                         output int dbin_cnt, output int doe_cnt,
                         output logic [7:0] dodd_and, output logic [7:0] dodd_or,
                         output logic [7:0] deven_and, output logic [7:0] deven_or,
                         output logic [14:0] addr_and, output logic [14:0] addr_or,
                         output logic err_at, output logic [15:0] rdata_at);
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wdata = d; bus_ready = 1'b1;
    @(negedge clk);
    req = 1'b0;
    done_cyc = 0; busy1 = busy;
    mem_odd = 0; mem_even = 0; we_odd = 0; we_even = 0; dbin_cnt = 0; doe_cnt = 0;
    dodd_and = 8'hFF; dodd_or = 8'h00; deven_and = 8'hFF; deven_or = 8'h00;
    addr_and = 15'h7FFF; addr_or = 15'h0000; err_at = 1'b0; rdata_at = 16'h0000;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (!memen_n) begin
        if (bus_a15) begin
          mem_odd++;
          if (!we_n) we_odd++;
          dodd_and &= bus_dout; dodd_or |= bus_dout;
        end else begin
          mem_even++;
          if (!we_n) we_even++;
          deven_and &= bus_dout; deven_or |= bus_dout;
        end
        addr_and &= bus_addr; addr_or |= bus_addr;
        if (dbin) dbin_cnt++;
        if (bus_doe) doe_cnt++;
      end
      // Even byte: READY low through even-byte cycle 11+even_low, i.e. even_low waits.
      bus_ready = !(even_low > 0 && !memen_n && !bus_a15 && mem_even <= 11 + even_low);
      if (done) begin
        done_cyc = cyc; err_at = err; rdata_at = rdata;
        break;
      end
      @(negedge clk);
    end
    bus_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({memen_n, we_n, dbin, bus_doe, bus_a15, busy, done, err} !== 8'b1100_0000) begin
      $display("FAIL reset_ctrl: got %b expected 11000000", {memen_n, we_n, dbin, bus_doe, bus_a15, busy, done, err});
    end else passed++;
    checks++;
    if ({bus_addr, bus_dout, rdata, phi3} !== 40'h0) begin
      $display("FAIL reset_data: got %h expected 0", {bus_addr, bus_dout, rdata, phi3});
    end else passed++;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, done, memen_n} !== 3'b001) begin
      $display("FAIL reset_release_idle: got %b expected 001", {busy, done, memen_n});
    end else passed++;
  endtask

  task automatic test_write;
    int dc, mo, me, wo, we, dbc, doc;
    logic b1, e;
    logic [7:0] doa, doo, dea, deo;
    logic [14:0] aa, ao;
    logic [15:0] rd;
    run_txn(1'b1, 16'h6000, 16'hA55A, 0, dc, b1, mo, me, wo, we, dbc, doc, doa, doo, dea, deo, aa, ao, e, rd);
    checks++; if (b1 !== 1'b1) $display("FAIL wr_busy_c1: got %b expected 1", b1); else passed++;
    checks++; if (dc !== 29) $display("FAIL wr_done_cycle: got %0d expected 29", dc); else passed++;
    checks++; if (e !== 1'b0) $display("FAIL wr_err: got %b expected 0", e); else passed++;
    checks++; if ({wo, we} !== {32'd8, 32'd8}) $display("FAIL wr_we_low: got %0d/%0d expected 8/8", wo, we); else passed++;
    checks++; if ({mo, me} !== {32'd14, 32'd14}) $display("FAIL wr_byte_len: got %0d/%0d expected 14/14", mo, me); else passed++;
    checks++; if ({doa, doo} !== 16'h5A5A) $display("FAIL wr_dout_odd: got %h/%h expected 5a", doa, doo); else passed++;
    checks++; if ({dea, deo} !== 16'hA5A5) $display("FAIL wr_dout_even: got %h/%h expected a5", dea, deo); else passed++;
    checks++; if ({aa, ao} !== {15'h3000, 15'h3000}) $display("FAIL wr_addr: got %h/%h expected 3000", aa, ao); else passed++;
    checks++; if ({doc, dbc} !== {32'd28, 32'd0}) $display("FAIL wr_doe_dbin: got %0d/%0d expected 28/0", doc, dbc); else passed++;
  endtask

  task automatic test_read;
    int dc, mo, me, wo, we, dbc, doc;
    logic b1, e;
    logic [7:0] doa, doo, dea, deo;
    logic [14:0] aa, ao;
    logic [15:0] rd;
    din_odd = 8'h12; din_even = 8'h34;
    run_txn(1'b0, 16'h8400, 16'hFFFF, 0, dc, b1, mo, me, wo, we, dbc, doc, doa, doo, dea, deo, aa, ao, e, rd);
    checks++; if (dc !== 29) $display("FAIL rd_done_cycle: got %0d expected 29", dc); else passed++;
    checks++; if (rd !== 16'h3412) $display("FAIL rd_rdata: got %h expected 3412", rd); else passed++;
    checks++; if ({dbc, doc} !== {32'd28, 32'd0}) $display("FAIL rd_dbin_doe: got %0d/%0d expected 28/0", dbc, doc); else passed++;
    checks++; if ({wo, we} !== 64'd0) $display("FAIL rd_we: got %0d/%0d expected 0/0", wo, we); else passed++;
    checks++; if ({aa, ao} !== {15'h4200, 15'h4200}) $display("FAIL rd_addr: got %h/%h expected 4200", aa, ao); else passed++;
  endtask

  task automatic test_read_wait;
    int dc, mo, me, wo, we, dbc, doc;
    logic b1, e;
    logic [7:0] doa, doo, dea, deo;
    logic [14:0] aa, ao;
    logic [15:0] rd;
    din_odd = 8'hC3; din_even = 8'h7E;
    run_txn(1'b0, 16'h1235, 16'h0000, 5, dc, b1, mo, me, wo, we, dbc, doc, doa, doo, dea, deo, aa, ao, e, rd);
    checks++; if (dc !== 34) $display("FAIL wait_done_cycle: got %0d expected 34", dc); else passed++;
    checks++; if (rd !== 16'h7EC3) $display("FAIL wait_rdata: got %h expected 7ec3", rd); else passed++;
    checks++; if ({mo, me} !== {32'd14, 32'd19}) $display("FAIL wait_byte_len: got %0d/%0d expected 14/19", mo, me); else passed++;
    checks++; if ({aa, ao, e} !== {15'h091A, 15'h091A, 1'b0}) $display("FAIL wait_addr_err: got %h/%h/%b expected 091a/091a/0", aa, ao, e); else passed++;
  endtask

  task automatic run_txn2(input logic r, input logic [7:0] d, output int dc, output int mo, output int me);
    @(negedge clk);
    req2 = 1'b1; wr = 1'b0; addr = 16'h4000; ready2 = r; din2 = d;
    @(negedge clk);
    req2 = 1'b0;
    dc = 0; mo = 0; me = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (!memen_n2) begin
        if (a15_2) mo++; else me++;
      end
      if (done2) begin dc = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout;
    int dc, mo, me;
    run_txn2(1'b1, 8'h5A, dc, mo, me);
    checks++; if ({dc, rdata2, err2} !== {32'd29, 16'h5A5A, 1'b0}) $display("FAIL to_prime: got %0d/%h/%b expected 29/5a5a/0", dc, rdata2, err2); else passed++;
    run_txn2(1'b0, 8'hFF, dc, mo, me);
    checks++; if (dc !== 18) $display("FAIL to_done_cycle: got %0d expected 18", dc); else passed++;
    checks++; if (err2 !== 1'b1) $display("FAIL to_err: got %b expected 1", err2); else passed++;
    checks++; if (rdata2 !== 16'h5A5A) $display("FAIL to_rdata_kept: got %h expected 5a5a", rdata2); else passed++;
    checks++; if ({mo, me} !== {32'd17, 32'd0}) $display("FAIL to_cycles: got %0d/%0d expected 17/0", mo, me); else passed++;
    run_txn2(1'b1, 8'h66, dc, mo, me);
    checks++; if ({dc, rdata2, err2} !== {32'd29, 16'h6666, 1'b0}) $display("FAIL to_recover: got %0d/%h/%b expected 29/6666/0", dc, rdata2, err2); else passed++;
    ready2 = 1'b1;
  endtask

  task automatic test_reset_mid;
    int dc, mo, me, wo, we, dbc, doc, stray;
    logic b1, e;
    logic [7:0] doa, doo, dea, deo;
    logic [14:0] aa, ao;
    logic [15:0] rd;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 16'h6000; wdata = 16'h1357;
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if ({memen_n, we_n} !== 2'b00) $display("FAIL rstmid_pre: got %b expected 00", {memen_n, we_n}); else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if ({memen_n, we_n, bus_doe, busy} !== 4'b1100) $display("FAIL rstmid_abort: got %b expected 1100", {memen_n, we_n, bus_doe, busy}); else passed++;
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    checks++; if (stray !== 0) $display("FAIL rstmid_no_done: got %0d expected 0", stray); else passed++;
    run_txn(1'b1, 16'h0010, 16'h2468, 0, dc, b1, mo, me, wo, we, dbc, doc, doa, doo, dea, deo, aa, ao, e, rd);
    checks++;
    if ({dc, e, dea, doa} !== {32'd29, 1'b0, 8'h24, 8'h68}) $display("FAIL rstmid_after: got %0d/%b/%h/%h expected 29/0/24/68", dc, e, dea, doa); else passed++;
  endtask

  task automatic test_back_to_back;
    int first_done, second_done, extra;
    logic busy30, busy31;
    logic [7:0] dout1_even, dout2_even;
    first_done = 0; second_done = 0; extra = 0;
    busy30 = 1'bx; busy31 = 1'bx; dout1_even = 8'h00; dout2_even = 8'h00;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 16'h2000; wdata = 16'h1234; bus_ready = 1'b1; phi_en = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 110; cyc++) begin
      if (cyc == 5) wdata = 16'hBEEF;
      if (!memen_n && !bus_a15) begin
        if (first_done == 0) dout1_even = bus_dout;
        else                 dout2_even = bus_dout;
      end
      if (cyc == 30) busy30 = busy;
      if (cyc == 31) begin busy31 = busy; req = 1'b0; end
      if (cyc == 40) req = 1'b1;
      if (cyc == 41) req = 1'b0;
      if (second_done != 0 && busy) extra++;
      if (done) begin
        if (first_done == 0)       first_done = cyc;
        else if (second_done == 0) second_done = cyc;
        else                       extra++;
      end
      @(negedge clk);
    end
    phi_en = 1'b0;
    checks++; if (first_done !== 29) $display("FAIL b2b_done1: got %0d expected 29", first_done); else passed++;
    checks++; if (second_done !== 59) $display("FAIL b2b_done2: got %0d expected 59", second_done); else passed++;
    checks++; if ({busy30, busy31} !== 2'b01) $display("FAIL b2b_restart: got %b expected 01", {busy30, busy31}); else passed++;
    checks++; if (extra !== 0) $display("FAIL b2b_pulse_ignored: got %0d expected 0", extra); else passed++;
    checks++; if ({dout1_even, dout2_even} !== 16'h12BE) $display("FAIL b2b_wdata: got %h expected 12be", {dout1_even, dout2_even}); else passed++;
    checks++; if ({phi_min, phi_max} !== {32'd17, 32'd17}) $display("FAIL phi3_period: got %0d/%0d expected 17/17", phi_min, phi_max); else passed++;
    checks++; if (phi_n < 4) $display("FAIL phi3_toggles: got %0d expected >=4", phi_n); else passed++;
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; wr = 1'b0; addr = 16'h0; wdata = 16'h0;
    bus_ready = 1'b1; din_odd = 8'h00; din_even = 8'h00;
    req2 = 1'b0; ready2 = 1'b1; din2 = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_read_wait();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tms_bus_master.md
Name: tms_bus_master

Overview:
- Host-side initiator for the TI-99/4A 8-bit multiplexed expansion bus. It generates the memory cycles that our bus-responder logic decodes.
- It turns single 16-bit word requests into the two byte cycles the 4A uses: odd byte first with A15=1, then even byte with A15=0. It drives MEMEN, DBIN, WE and a free-running PHI3.
- It lets the board act as a bench/host for cartridge-side designs, replacing the console for bring-up and regression.

Parameters:
T_SETUP, 4, clk cycles per byte cycle with address/MEMEN/DBIN valid before strobe
T_STROBE, 8, minimum clk cycles of strobe phase (WE low on writes, data sample window on reads)
T_HOLD, 2, clk cycles with address/data held after strobe, MEMEN still low
WAIT_MAX, 255, max extra strobe cycles spent waiting on bus_ready before abort
PHI3_DIV, 17, clk cycles per PHI3 half-period

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-low reset
req  input  1  start transaction; sampled only while idle
wr  input  1  1=write, 0=read; captured with req
addr  input  16  byte address; bit 0 ignored (word access)
wdata  input  16  write word; captured with req
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse at end of transaction
err  output  1  valid with done; 1 = wait timeout abort
rdata  output  16  read word; valid with done, held until next acceptance
bus_addr  output  15  A0..A14 (byte address bits 15:1)
bus_a15  output  1  byte select: 1=odd/low byte, 0=even/high byte
memen_n  output  1  memory enable, active low
dbin  output  1  high during read cycles
we_n  output  1  write strobe, active low
bus_ready  input  1  responder READY; low inserts wait states
bus_dout  output  8  byte driven on data bus
bus_doe  output  1  data bus output enable
bus_din  input  8  byte from data bus
phi3  output  1  free-running clock, 50% duty, period 2*PHI3_DIV clk

Behaviour:
- Reset (async assert, sync release): memen_n=1, we_n=1, dbin=0, bus_doe=0, bus_a15=0, bus_addr=0, bus_dout=0, busy=0, done=0, err=0, rdata=0, phi3=0, state IDLE. Assertion mid-transaction aborts immediately with no done.
- PHI3 divider runs regardless of state, restarts from 0 at reset. Not synchronised to bus cycles.
- States:
  - IDLE: req=1 latches wr/addr/wdata, sets byte_sel=odd, goes to SETUP; busy=1 from the next cycle.
  - SETUP, T_SETUP cycles: memen_n=0, bus_addr=addr[15:1], bus_a15=byte_sel, dbin=!wr. Writes: bus_doe=1, bus_dout=wdata[7:0] (odd) or wdata[15:8] (even).
  - STROBE, at least T_STROBE cycles: we_n=0 on writes. On the last counted cycle (and each later cycle), bus_ready=1 ends the phase.
    - Reads: bus_din is captured into rdata[7:0] (odd) or rdata[15:8] (even) on the edge leaving STROBE.
    - bus_ready=0 extends STROBE, counting waits. Reaching WAIT_MAX waits goes to HOLD with err latched and no capture.
  - HOLD, T_HOLD cycles: we_n=1, memen_n stays 0, address/data held.
    - Odd byte without err: byte_sel=even, back to SETUP.
    - Otherwise: go to DONE. An err skips the even byte.
  - DONE, 1 cycle: memen_n=1, dbin=0, bus_doe=0, done=1, busy=0. Next state IDLE.
- Timing:
  - No-wait byte cycle = T_SETUP+T_STROBE+T_HOLD = 14 clk.
  - Word = 28 clk + 1 DONE. done asserts exactly 29 cycles after the cycle busy first rises.
- req while busy or in DONE is ignored (no queue). A req held high starts the next transaction in the IDLE cycle after DONE.
- err clears on the next acceptance. rdata bytes not captured (abort) keep their previous value.

Test Plan:
- Write 0xA55A to addr 0x6000, bus_ready=1: odd cycle bus_a15=1, bus_dout=0x5A, then even cycle bus_a15=0, bus_dout=0xA5. bus_addr=0x3000 both cycles; we_n low 8 clk each; done at cycle 29, err=0.
- Read addr 0x8400, bus_din=0x12 on odd and 0x34 on even: dbin=1, bus_doe=0 throughout; rdata=0x3412 at done.
- Read with bus_ready low 5 extra cycles on the even byte: STROBE lasts 13 clk; done at cycle 34; data captured correctly.
- bus_ready stuck low with WAIT_MAX=3: after odd STROBE 8+3 cycles, go to HOLD, then DONE. done=1, err=1, no even cycle, rdata unchanged.
- Reset low at cycle 10 of a write: memen_n=1, we_n=1, bus_doe=0, busy=0 combinationally. No done pulse; a new req after release completes normally.
- req held high across two transactions, plus a req pulse while busy: second transaction starts the cycle after DONE; the mid-transaction pulse has no effect. phi3 toggles every 17 clk throughout.
